weight_buffer: RTL and testbench

Synthesizable on-chip weight store for the convolution accelerator: the receiving end of the weight flush stream (`flush`, `flush_VALID`, `data_in`). It captures one kernel of `DEPTH` weights, then serves them in order to the PE array through a show-ahead read port, wrapping so the same kernel can be reused across output pixels. It sits between the weight load path and the PE weight inputs.

---
 rtl/weight_buffer.sv | 121 ++++++++++++
 tb/tb_weight_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer.sv
// ============================================================================
//  Module   : weight_buffer
//  Purpose  : Captures one kernel of DEPTH weights from the flush stream and
//             serves it to the PE array through a wrapping show-ahead port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module weight_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  flush_VALID,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  load_done,
    input  logic                  w_rd_en,
    input  logic                  rewind,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  w_valid,
    output logic                  w_last,
    output logic                  overflow
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_d;
    logic                    load_done_q;
    logic                    w_valid_q;
    logic                    overflow_q;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // flush outranks any same-cycle data word, so it also gates the write
    assign mem_we = (state_q == ST_LOAD) && flush_VALID && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (rewind) begin
            rd_ptr_d = '0;
        end else if (w_rd_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            load_done_q <= 1'b0;
            w_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            load_done_q <= 1'b0;
            w_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_VALID) begin
                        overflow_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (flush_VALID) begin
                        if (wr_ptr_q == LAST_IDX) begin
                            wr_ptr_q    <= '0;
                            rd_ptr_q    <= '0;
                            state_q     <= ST_READY;
                            load_done_q <= 1'b1;
                            w_valid_q   <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (flush_VALID) begin
                        overflow_q <= 1'b1;
                    end
                    rd_ptr_q <= rd_ptr_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately left unreset; validity is tracked by the FSM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign load_done = load_done_q;
    assign w_valid   = w_valid_q;
    assign w_out     = w_valid_q ? mem[rd_ptr_q] : '0;
    assign w_last    = w_valid_q && (rd_ptr_q == LAST_IDX);
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_weight_buffer.sv
// ============================================================================
//  Module   : tb_weight_buffer
//  Purpose  : Directed self-checking bench for weight_buffer (DEPTH=9).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_weight_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        flush_VALID;
    logic [15:0] data_in;
    logic        load_done;
    logic        w_rd_en;
    logic        rewind;
    logic [15:0] w_out;
    logic        w_valid;
    logic        w_last;
    logic        overflow;

    int errors;
    int checks;

    weight_buffer #(
        .DATA_WIDTH (16),
        .DEPTH      (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .flush_VALID (flush_VALID),
        .data_in     (data_in),
        .load_done   (load_done),
        .w_rd_en     (w_rd_en),
        .rewind      (rewind),
        .w_out       (w_out),
        .w_valid     (w_valid),
        .w_last      (w_last),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".load_done"}, 32'(load_done), 32'd0);
        chk({tag, ".w_valid"},   32'(w_valid),   32'd0);
        chk({tag, ".w_last"},    32'(w_last),    32'd0);
        chk({tag, ".w_out"},     32'(w_out),     32'd0);
        chk({tag, ".overflow"},  32'(overflow),  32'd0);
    endtask

    // Pops n words at full rate, expecting base+1 .. base+9 in wrapping order.
    task automatic pop_check(input string tag, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            chk({tag, ".w_out"},  32'(w_out),  32'(base + 16'(k % 9 + 1)));
            chk({tag, ".w_last"}, 32'(w_last), (k % 9 == 8) ? 32'd1 : 32'd0);
            w_rd_en = 1'b1;
            tick();
        end
        w_rd_en = 1'b0;
    endtask

    task automatic load_words(input int n, input logic [15:0] base, input bit gaps);
        for (int i = 1; i <= n; i++) begin
            flush_VALID = 1'b1;
            data_in     = base + 16'(i);
            tick();
            if (i < 9) chk("load.no_done_early", 32'(load_done), 32'd0);
            if (gaps && i < n) begin
                flush_VALID = 1'b0;
                data_in     = 16'hDEAD;
                tick();
                chk("gap.no_done_early", 32'(load_done), 32'd0);
            end
        end
        flush_VALID = 1'b0;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        flush_VALID = 1'b0;
        data_in     = '0;
        w_rd_en     = 1'b0;
        rewind      = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Gap-free load of 1..9
        flush = 1'b1;
        tick();
        flush = 1'b0;
        load_words(9, 16'h0000, 1'b0);
        chk("load1.load_done", 32'(load_done), 32'd1);
        chk("load1.w_valid",   32'(w_valid),   32'd1);
        chk("load1.w_out",     32'(w_out),     32'd1);
        chk("load1.w_last",    32'(w_last),    32'd0);

        // Ten full-rate pops: 1..9 then wrap to 1, ptr ends at entry 1
        pop_check("pop10", 10, 16'h0000);
        chk("pop10.after", 32'(w_out), 32'd2);

        // Plain rewind, then rewind colliding with a pop
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        chk("rewind.alone", 32'(w_out), 32'd1);
        pop_check("pop4", 4, 16'h0000);
        chk("pop4.after", 32'(w_out), 32'd5);
        rewind  = 1'b1;
        w_rd_en = 1'b1;
        tick();
        rewind  = 1'b0;
        w_rd_en = 1'b0;
        chk("rewind.with_pop", 32'(w_out), 32'd1);
        tick();
        chk("rewind.hold", 32'(w_out), 32'd1);

        // Stray word in READY: overflow set, contents intact
        flush_VALID = 1'b1;
        data_in     = 16'hBEEF;
        tick();
        flush_VALID = 1'b0;
        chk("ovf.set",    32'(overflow), 32'd1);
        chk("ovf.w_out",  32'(w_out),    32'd1);
        pop_check("ovf.pop", 9, 16'h0000);
        chk("ovf.sticky", 32'(overflow), 32'd1);

        // flush in READY clears everything visible
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle_outputs("flush_ready");

        // Gapped load (flush already issued above)
        load_words(9, 16'h0A00, 1'b1);
        chk("gap.load_done", 32'(load_done), 32'd1);
        chk("gap.w_out",     32'(w_out),     32'h0A01);
        pop_check("gap.pop", 9, 16'h0A00);

        // Async reset in READY with overflow set
        flush_VALID = 1'b1;
        data_in     = 16'h1234;
        tick();
        flush_VALID = 1'b0;
        chk("ovf2.set", 32'(overflow), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst_ready");
        rst = 1'b0;
        tick();

        // Word in IDLE is discarded and flags overflow
        flush_VALID = 1'b1;
        data_in     = 16'h7777;
        tick();
        flush_VALID = 1'b0;
        chk("idle.ovf", 32'(overflow), 32'd1);
        chk("idle.w_valid", 32'(w_valid), 32'd0);

        // flush with same-cycle data: data dropped, overflow cleared
        flush       = 1'b1;
        flush_VALID = 1'b1;
        data_in     = 16'h5555;
        tick();
        flush       = 1'b0;
        chk("flushprio.ovf", 32'(overflow), 32'd0);
        load_words(5, 16'h0B00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst_load");
        rst = 1'b0;
        tick();

        // Clean reload after mid-load reset
        flush       = 1'b1;
        flush_VALID = 1'b1;
        data_in     = 16'h5555;
        tick();
        flush       = 1'b0;
        load_words(9, 16'h0030, 1'b0);
        chk("reload.load_done", 32'(load_done), 32'd1);
        chk("reload.w_out",     32'(w_out),     32'h0031);
        pop_check("reload.pop", 10, 16'h0030);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
